// File: rtl/pixel_hinterp_2x.sv
// Horizontal 2x pixel upsampler: emits each input pixel followed by its rounded
// per-channel average with the right neighbour; the last pixel of a line is repeated.
module pixel_hinterp_2x #(
    parameter int PIXEL_WIDTH   = 24,
    parameter int CHANNEL_WIDTH = 8,
    parameter int LINE_PIXELS   = 1920
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIXEL_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [PIXEL_WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    localparam int NUM_CH = PIXEL_WIDTH / CHANNEL_WIDTH;
    localparam int COL_W  = ($clog2(LINE_PIXELS + 1) > 1) ? $clog2(LINE_PIXELS + 1) : 1;
    localparam logic [COL_W-1:0]       LAST_COL = COL_W'(LINE_PIXELS - 1);
    localparam logic [COL_W-1:0]       COL_ONE  = COL_W'(1);
    localparam logic [CHANNEL_WIDTH:0] RND_ONE  = (CHANNEL_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_FIRST,
        S_NEXT,
        S_ORIG,
        S_DUP
    } state_t;

    state_t                 state_q;
    logic [COL_W-1:0]       col_q;
    logic [PIXEL_WIDTH-1:0] prev_q;
    logic [PIXEL_WIDTH-1:0] cur_q;
    logic [PIXEL_WIDTH-1:0] out_data_q;
    logic                   out_valid_q;
    logic                   out_last_q;
    logic                   slot_free;

    // One extra bit per channel keeps the +1 rounding carry out of the neighbour channel.
    function automatic logic [PIXEL_WIDTH-1:0] avg_round(input logic [PIXEL_WIDTH-1:0] a,
                                                         input logic [PIXEL_WIDTH-1:0] b);
        logic [PIXEL_WIDTH-1:0] r;
        logic [CHANNEL_WIDTH:0] s;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s = {1'b0, a[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]}
              + {1'b0, b[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]} + RND_ONE;
            r[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = s[CHANNEL_WIDTH:1];
        end
        return r;
    endfunction

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = ((state_q == S_FIRST) || (state_q == S_NEXT)) && slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FIRST;
            col_q       <= '0;
            prev_q      <= '0;
            cur_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (slot_free) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            case (state_q)
                S_FIRST: begin
                    if (in_valid) begin
                        out_data_q  <= in_data;
                        prev_q      <= in_data;
                        out_valid_q <= 1'b1;
                        col_q       <= COL_ONE;
                        state_q     <= (LINE_PIXELS == 1) ? S_DUP : S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (in_valid) begin
                        out_data_q  <= avg_round(prev_q, in_data);
                        cur_q       <= in_data;
                        out_valid_q <= 1'b1;
                        state_q     <= S_ORIG;
                    end
                end
                S_ORIG: begin
                    out_data_q  <= cur_q;
                    prev_q      <= cur_q;
                    out_valid_q <= 1'b1;
                    col_q       <= col_q + COL_ONE;
                    state_q     <= (col_q == LAST_COL) ? S_DUP : S_NEXT;
                end
                S_DUP: begin
                    out_data_q  <= prev_q;
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b1;
                    col_q       <= '0;
                    state_q     <= S_FIRST;
                end
                default: state_q <= S_FIRST;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_pixel_hinterp_2x.sv
// Bench for pixel_hinterp_2x: three instances (4, 2 and 1 pixel lines) driven one at a
// time and compared against a line-level reference of the expected 2x output stream.
module tb_pixel_hinterp_2x;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] in_data   [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [23:0] out_data  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic        out_last  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pixel_hinterp_2x #(
            .PIXEL_WIDTH  (24),
            .CHANNEL_WIDTH(8),
            .LINE_PIXELS  ((g == 0) ? 4 : ((g == 1) ? 2 : 1))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_data  (in_data[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .out_data (out_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_last (out_last[g])
        );
    end

    int total  = 0;
    int passed = 0;

    logic [23:0] in_q  [$];
    logic [23:0] exp_d [$];
    logic        exp_l [$];
    logic [23:0] lp    [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    endtask

    function automatic logic [23:0] avg_ref(input logic [23:0] a, input logic [23:0] b);
        int ca, cb;
        logic [23:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            ca = int'((a >> (8 * c)) & 24'hFF);
            cb = int'((b >> (8 * c)) & 24'hFF);
            r  = r | 24'(((ca + cb + 1) / 2) << (8 * c));
        end
        return r;
    endfunction

    // Expected stream of a line p0..pN-1: p0, avg(p0,p1), p1, ..., pN-1, pN-1 (last flagged)
    task automatic push_line(input logic [23:0] px[$]);
        int n;
        n = px.size();
        for (int i = 0; i < n; i++) begin
            in_q.push_back(px[i]);
            exp_d.push_back(px[i]);
            exp_l.push_back(1'b0);
            if (i < n - 1) exp_d.push_back(avg_ref(px[i], px[i+1]));
            else           exp_d.push_back(px[i]);
            exp_l.push_back(i == n - 1);
        end
    endtask

    task automatic rand_line(input int n);
        logic [23:0] px[$];
        logic [23:0] p;
        int sel;
        for (int i = 0; i < n; i++) begin
            p = '0;
            for (int c = 0; c < 3; c++) begin
                sel = int'($urandom_range(0, 3));
                if (sel == 0)      p[c*8 +: 8] = 8'hFF;
                else if (sel == 1) p[c*8 +: 8] = 8'h00;
                else               p[c*8 +: 8] = 8'($urandom_range(0, 255));
            end
            px.push_back(p);
        end
        push_line(px);
    endtask

    // mode 0: full rate; mode 1: out_ready pattern 1,0,0 repeating; mode 2: random both sides
    task automatic run(input int d, input int mode, input int stop_after);
        int   cyc, nacc, phase;
        logic started, stall_prev, hold_l;
        logic [23:0] hold_d;
        cyc = 0; nacc = 0; phase = 0;
        started = 1'b0; stall_prev = 1'b0; hold_l = 1'b0; hold_d = '0;
        while (exp_d.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            case (mode)
                0:       out_ready[d] = 1'b1;
                1:       out_ready[d] = (phase % 3 == 0);
                default: out_ready[d] = 1'($urandom_range(0, 1));
            endcase
            phase++;
            if (in_q.size() > 0) begin
                in_valid[d] = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data[d]  = in_q[0];
            end else begin
                in_valid[d] = 1'b0;
                in_data[d]  = 24'($urandom);
            end
            #1;
            if (stall_prev) begin
                check("hold_data", {8'h0, out_data[d]}, {8'h0, hold_d});
                check("hold_last", {31'h0, out_last[d]}, {31'h0, hold_l});
            end
            if (out_valid[d] && !out_ready[d])
                check("stall_in_ready", {31'h0, in_ready[d]}, 32'h0);
            if (out_valid[d] && out_last[d])
                check("last_in_ready", {31'h0, in_ready[d]}, {31'h0, out_ready[d]});
            if (mode == 0 && started)
                check("no_bubble", {31'h0, out_valid[d]}, 32'h1);
            if (out_valid[d] && out_ready[d]) begin
                check("out_data", {8'h0, out_data[d]}, {8'h0, exp_d[0]});
                check("out_last", {31'h0, out_last[d]}, {31'h0, exp_l[0]});
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
                started = 1'b1;
            end
            if (in_valid[d] && in_ready[d]) begin
                void'(in_q.pop_front());
                nacc++;
            end
            stall_prev = out_valid[d] && !out_ready[d];
            hold_d     = out_data[d];
            hold_l     = out_last[d];
            @(posedge clk);
            cyc++;
            if (stop_after > 0 && nacc >= stop_after) break;
        end
        if (cyc >= 3000) check("timeout", exp_d.size(), 0);
        if (stop_after == 0) begin
            @(negedge clk);
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            #1;
            check("idle_valid", {31'h0, out_valid[d]}, 32'h0);
            check("idle_in_ready", {31'h0, in_ready[d]}, 32'h1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            out_ready[d] = 1'b1;
        end
        #12;
        for (int d = 0; d < 3; d++) begin
            check("rst_valid", {31'h0, out_valid[d]}, 32'h0);
            check("rst_last", {31'h0, out_last[d]}, 32'h0);
            check("rst_data", {8'h0, out_data[d]}, 32'h0);
            check("rst_in_ready", {31'h0, in_ready[d]}, 32'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        lp = '{24'h000000, 24'h0A0A0A, 24'h141414, 24'h1E1E1E};
        push_line(lp);
        run(0, 0, 0);

        lp = '{24'hFF01FF, 24'h0000FE};
        push_line(lp);
        run(1, 0, 0);

        lp = '{24'h000000, 24'h0A0A0A, 24'h141414, 24'h1E1E1E};
        push_line(lp);
        rand_line(4);
        rand_line(4);
        run(0, 1, 0);

        rand_line(2);
        rand_line(2);
        run(1, 0, 0);

        lp = '{24'h123456};
        push_line(lp);
        run(2, 0, 0);
        for (int i = 0; i < 4; i++) rand_line(1);
        run(2, 2, 0);

        for (int i = 0; i < 4; i++) rand_line(4);
        run(0, 2, 0);
        for (int i = 0; i < 3; i++) rand_line(2);
        run(1, 2, 0);

        lp = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        push_line(lp);
        run(0, 0, 3);
        in_valid[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, out_valid[0]}, 32'h0);
        check("mid_rst_last", {31'h0, out_last[0]}, 32'h0);
        check("mid_rst_data", {8'h0, out_data[0]}, 32'h0);
        in_q.delete();
        exp_d.delete();
        exp_l.delete();
        @(negedge clk);
        rst_n = 1'b1;
        lp = '{24'h0C0C0C, 24'h202020, 24'hFFFFFF, 24'h010101};
        push_line(lp);
        run(0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
